// File: rtl/collision_edge_detector_pkg.sv
// Shared defines for the collision edge detector.
// Tile geometry defaults, edge-bit indices and FSM states.
package collision_edge_detector_pkg;

  localparam int OBST_W_DEF    = 64;
  localparam int OBST_H_DEF    = 32;
  localparam int EDGE_BAND_DEF = 4;

  localparam int EDGE_LEFT   = 3;
  localparam int EDGE_TOP    = 2;
  localparam int EDGE_RIGHT  = 1;
  localparam int EDGE_BOTTOM = 0;

  localparam int EW    = 4;
  localparam int CNT_W = 8;
  localparam int OFS_W = 11;

  typedef enum logic {
    SCAN   = 1'b0,
    REPORT = 1'b1
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/collision_edge_detector_if.sv
// Pixel/collision bundle for the collision edge detector.
// master drives the scan side, slave is the detector.
interface collision_edge_detector_if;
  import collision_edge_detector_pkg::*;

  logic             startOfFrame;
  logic             pause;
  logic             reset_level;
  logic             smileyDrawingRequest;
  logic             obstacleDrawingRequest;
  logic [OFS_W-1:0] offsetX;
  logic [OFS_W-1:0] offsetY;
  logic             collisionSmileyObstacleReal;
  logic             collisionSmileyObstacle;
  logic [EW-1:0]    hitEdgeCode;
  logic [CNT_W-1:0] hitCount;

  modport master (
    output startOfFrame, pause, reset_level,
    output smileyDrawingRequest,
    output obstacleDrawingRequest,
    output offsetX, offsetY,
    output collisionSmileyObstacleReal,
    input  collisionSmileyObstacle,
    input  hitEdgeCode, hitCount
  );

  modport slave (
    input  startOfFrame, pause, reset_level,
    input  smileyDrawingRequest,
    input  obstacleDrawingRequest,
    input  offsetX, offsetY,
    input  collisionSmileyObstacleReal,
    output collisionSmileyObstacle,
    output hitEdgeCode, hitCount
  );

endinterface

// File: rtl/collision_edge_detector_hit_edge_classifier.sv
// Per-pixel edge classification inside an obstacle tile.
// Corner pixels may set two bits at once.
module hit_edge_classifier
  import collision_edge_detector_pkg::*;
#(
  parameter int OBST_W    = OBST_W_DEF,
  parameter int OBST_H    = OBST_H_DEF,
  parameter int EDGE_BAND = EDGE_BAND_DEF
) (
  input  logic [OFS_W-1:0] offset_x,
  input  logic [OFS_W-1:0] offset_y,
  output logic [EW-1:0]    edges
);

  localparam logic [OFS_W-1:0] X_HI =
    OFS_W'(OBST_W - EDGE_BAND);
  localparam logic [OFS_W-1:0] Y_HI =
    OFS_W'(OBST_H - EDGE_BAND);
  localparam logic [OFS_W-1:0] BAND =
    OFS_W'(EDGE_BAND);

  always_comb begin
    edges              = '0;
    edges[EDGE_LEFT]   = offset_x >= X_HI;
    edges[EDGE_RIGHT]  = offset_x <  BAND;
    edges[EDGE_TOP]    = offset_y >= Y_HI;
    edges[EDGE_BOTTOM] = offset_y <  BAND;
  end

endmodule

// File: rtl/collision_edge_detector.sv
// Accumulates edge contacts per frame and reports one pulse.
// Also counts acknowledged hits per level.
module collision_edge_detector
  import collision_edge_detector_pkg::*;
#(
  parameter int OBST_W    = OBST_W_DEF,
  parameter int OBST_H    = OBST_H_DEF,
  parameter int EDGE_BAND = EDGE_BAND_DEF
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             startOfFrame,
  input  logic             pause,
  input  logic             reset_level,
  input  logic             smileyDrawingRequest,
  input  logic             obstacleDrawingRequest,
  input  logic [OFS_W-1:0] offsetX,
  input  logic [OFS_W-1:0] offsetY,
  input  logic             collisionSmileyObstacleReal,
  output logic             collisionSmileyObstacle,
  output logic [EW-1:0]    hitEdgeCode,
  output logic [CNT_W-1:0] hitCount
);

  state_e           state_q, state_d;
  logic [EW-1:0]    acc_q, acc_d;
  logic [EW-1:0]    hit_edge_q, hit_edge_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [EW-1:0] pix_edges;
  logic [EW-1:0] pix_add;
  logic          overlap;

  hit_edge_classifier #(
    .OBST_W    (OBST_W),
    .OBST_H    (OBST_H),
    .EDGE_BAND (EDGE_BAND)
  ) u_cls (
    .offset_x (offsetX),
    .offset_y (offsetY),
    .edges    (pix_edges)
  );

  assign overlap = smileyDrawingRequest
                 & obstacleDrawingRequest;
  assign pix_add = (overlap && !pause)
                 ? pix_edges : '0;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    hit_edge_d = hit_edge_q;
    pulse_d    = 1'b0;
    cnt_d      = cnt_q;
    if (reset_level) begin
      state_d    = SCAN;
      acc_d      = '0;
      hit_edge_d = '0;
      cnt_d      = '0;
    end else begin
      if (collisionSmileyObstacleReal)
        cnt_d = sat_inc(cnt_q);
      unique case (state_q)
        SCAN: begin
          // a pixel on the SOF cycle opens the new frame
          if (startOfFrame) begin
            hit_edge_d = acc_q;
            acc_d      = pix_add;
            pulse_d    = !pause && (|acc_q);
            state_d    = REPORT;
          end else begin
            acc_d = acc_q | pix_add;
          end
        end
        REPORT: state_d = SCAN;
        default: state_d = SCAN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= SCAN;
      acc_q      <= '0;
      hit_edge_q <= '0;
      pulse_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      hit_edge_q <= hit_edge_d;
      pulse_q    <= pulse_d;
      cnt_q      <= cnt_d;
    end
  end

  assign collisionSmileyObstacle = pulse_q;
  assign hitEdgeCode             = hit_edge_q;
  assign hitCount                = cnt_q;

endmodule

// File: doc/collision_edge_detector.md
COLLISION_EDGE_DETECTOR -- requirements
Module: collision_edge_detector

Interface
REQ-001 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  system clock
- resetN  in  1  asynchronous reset, active-low
- startOfFrame  in  1  one-cycle pulse at the start of each video frame
- pause  in  1  game paused
- reset_level  in  1  synchronous level restart
- smileyDrawingRequest  in  1  smiley pixel is opaque at the current scan pixel
- obstacleDrawingRequest  in  1  obstacle pixel is opaque at the current scan pixel
- offsetX  in  11  pixel X offset inside the obstacle tile, unsigned
- offsetY  in  11  pixel Y offset inside the obstacle tile, unsigned
- collisionSmileyObstacleReal  in  1  acknowledge pulse from the ball controller
- collisionSmileyObstacle  out  1  one-cycle obstacle-collision pulse
- hitEdgeCode  out  4  contact sides: [3] ball left, [2] ball top, [1] ball right, [0] ball bottom
- hitCount  out  8  number of acknowledged obstacle hits in the current level

REQ-002 SHALL have these parameters (name, default, meaning):
- OBST_W, 64, obstacle tile width in pixels
- OBST_H, 32, obstacle tile height in pixels
- EDGE_BAND, 4, edge band thickness in pixels

Function
REQ-003 SHALL treat a pixel as an overlap pixel when smileyDrawingRequest and obstacleDrawingRequest are both 1 in the same cycle.
REQ-004 SHALL classify each overlap pixel into edge bits as follows:
- offsetX >= OBST_W-EDGE_BAND sets bit3.
- offsetX < EDGE_BAND sets bit1.
- offsetY >= OBST_H-EDGE_BAND sets bit2.
- offsetY < EDGE_BAND sets bit0.
- Several bits may be set for one pixel (corner pixels).
REQ-005 SHALL OR the classified bits of every overlap pixel into a 4-bit accumulator edgeAcc during the SCAN state.
REQ-006 SHALL implement an FSM with states SCAN and REPORT, entering SCAN on reset.
REQ-007 SHALL handle a startOfFrame in SCAN as follows:
- Copy edgeAcc to hitEdgeCode.
- Clear edgeAcc.
- Go to REPORT.
- An overlap pixel in the same cycle as startOfFrame belongs to the new frame and is written into the cleared edgeAcc.
REQ-008 SHALL, in REPORT, assert collisionSmileyObstacle for exactly one cycle when hitEdgeCode is not 0000, then return to SCAN on the next cycle.
REQ-009 SHALL never assert collisionSmileyObstacle in the same cycle as startOfFrame.
- Latency: the pulse comes exactly one clock after startOfFrame.
REQ-010 SHALL keep hitEdgeCode stable from the REPORT cycle until the next startOfFrame.
REQ-011 SHALL emit no pulse for a frame whose overlap pixels all lie outside the edge bands.
- In that case hitEdgeCode is 0000.
REQ-012 SHALL behave as follows while pause=1:
- Hold edgeAcc; no accumulation.
- Suppress collisionSmileyObstacle.
- Still perform the startOfFrame copy and clear, so stale edges never survive a pause.
REQ-013 SHALL increment hitCount by 1 on each cycle in which collisionSmileyObstacleReal=1, saturating at 255.
REQ-014 SHALL give reset_level priority over all other events:
- Clear edgeAcc, hitEdgeCode and hitCount.
- Force collisionSmileyObstacle to 0.
- Force the FSM to SCAN.
- Ignore startOfFrame and acknowledge in that cycle.

Reset
REQ-015 SHALL, on resetN low, asynchronously reset the block as follows:
- collisionSmileyObstacle=0, hitEdgeCode=0000, hitCount=0.
- edgeAcc=0000, FSM in SCAN.
REQ-016 SHALL discard any partially accumulated frame when reset is asserted mid-frame.
- The first report after reset release covers only pixels seen after release.

Structure
REQ-017 SHALL take OBST_W, OBST_H and EDGE_BAND default values from the shared defines package.
- The edge-bit index constants (EDGE_LEFT=3, EDGE_TOP=2, EDGE_RIGHT=1, EDGE_BOTTOM=0) also live in that package.
REQ-018 SHALL place the per-pixel classification (REQ-004) in one combinational sub-module, hit_edge_classifier.
- The FSM, accumulator and counter stay in the top module.

Verification
REQ-019 SHALL pass this scenario: 3 overlap pixels at (offsetX,offsetY)=(62,10), then startOfFrame -> next cycle collisionSmileyObstacle=1 for one cycle, hitEdgeCode=1000.
REQ-020 SHALL pass this scenario: corner overlap pixel at (1,1), then startOfFrame -> hitEdgeCode=0011 and one pulse; following frame with no overlap -> hitEdgeCode=0000, no pulse.
REQ-021 SHALL pass this scenario: overlap pixel only at (30,15), then startOfFrame -> no pulse, hitEdgeCode=0000.
REQ-022 SHALL pass this scenario: overlap pixel at (30,30) with pause=1, then startOfFrame -> no pulse; after pause=0, next frame with no overlap -> hitEdgeCode=0000.
REQ-023 SHALL pass this scenario: 300 collisionSmileyObstacleReal pulses -> hitCount=255; then reset_level -> hitCount=0.
REQ-024 SHALL pass this scenario: overlap pixel at (2,20), then resetN low mid-frame, released, then startOfFrame -> no pulse, hitEdgeCode=0000.
